hilo_unit: RTL
==============

Name: hilo_unit

Overview:
- Sequencer and result stage between the datapath and the iterative multiply/divide core.
- On each MULT/MULTU/DIV/DIVU it:
  - converts signed operands to magnitudes;
  - launches the core with a one-cycle start pulse;
  - waits for completion, applies sign fixup and writes the architectural HI/LO registers.
- Also services MTHI/MTLO.
- Drives busy so the control unit stalls MFHI/MFLO and new mult/div ops.

Parameters:
- TIMEOUT, 64, maximum cycles spent in WAIT before aborting the operation.
- CW, 7, width of the WAIT cycle counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- op_start  in  1  one-cycle request; sampled only when busy=0.
- op_code  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved.
- rs_val  in  32  dividend / multiplicand / MTHI-MTLO source.
- rt_val  in  32  divisor / multiplier.
- core_start  out  1  one-cycle launch pulse to the core.
- core_is_div  out  1  1 = divide, 0 = multiply; held stable from LAUNCH through WAIT.
- core_a  out  32  unsigned magnitude of rs_val (raw value for unsigned ops); held stable from LAUNCH through WAIT.
- core_b  out  32  unsigned magnitude of rt_val (raw value for unsigned ops); held stable from LAUNCH through WAIT.
- core_done  in  1  one-cycle pulse from the core when its result is valid.
- core_res_hi  in  32  unsigned result, high half: product[63:32] or remainder.
- core_res_lo  in  32  unsigned result, low half: product[31:0] or quotient.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the cycle HI/LO are written by a mult/div.
- div0  out  1  one-cycle pulse for a signed or unsigned divide with rt_val==0.
- err_timeout  out  1  one-cycle pulse when a WAIT abort occurs.

Behaviour:
- Reset outputs: state IDLE; hi=lo=0; busy=done=div0=err_timeout=core_start=0; core_a=core_b=0; core_is_div=0; WAIT counter=0.
- Reset mid-operation has the same effect. A late core_done after reset is ignored.
- States: IDLE, LAUNCH, WAIT, FIXUP.
- IDLE, op_start=1:
  - MTHI/MTLO: hi (or lo) <= rs_val at that edge; stay IDLE; done not pulsed.
  - DIV/DIVU with rt_val==0: div0 pulses next cycle; HI/LO unchanged; no core_start; stay IDLE.
  - MULT/MULTU/DIV/DIVU otherwise: latch operands, magnitudes, sign flags and op; go to LAUNCH.
  - Reserved op_code: ignored.
- op_start while busy=1 is ignored.
- LAUNCH: core_start=1 for exactly this cycle; go to WAIT; clear counter.
- WAIT:
  - counter increments every cycle.
  - core_done=1: latch core_res_hi/lo; go to FIXUP.
  - Counter reaching TIMEOUT without core_done: err_timeout pulse; HI/LO unchanged; go to IDLE.
  - core_done on the same cycle the counter reaches TIMEOUT: done wins.
- FIXUP:
  - Writes HI/LO, pulses done, returns to IDLE. busy falls the cycle after FIXUP.
  - Minimum op latency, op_start to done: 3 + core latency cycles.
- Sign rules, signed ops only:
  - Multiply: 64-bit product is two's-complement negated when operand signs differ.
  - Divide, quotient (lo): negated when operand signs differ.
  - Divide, remainder (hi): takes the sign of the dividend.
  - Magnitude of 0x80000000 is 0x80000000 (unsigned).
  - Divide -2^31 / -1: lo=0x80000000, hi=0 (wrap, no exception).
- core_done outside WAIT is ignored.

Test Plan:
- DIV rs=7, rt=0xFFFFFFFE (-2) -> core_a=7, core_b=2; done pulse; lo=0xFFFFFFFD, hi=1.
- MULT rs=0xFFFFFFFD, rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU same operands -> hi=0x4, lo=0xFFFFFFF1.
- DIVU rs=9, rt=0 -> div0 pulse one cycle after op_start; core_start never asserted; HI/LO unchanged.
- DIV rs=0x80000000, rt=0xFFFFFFFF, core returns q=0x80000000 r=0 -> lo=0x80000000, hi=0.
- MULT with core_done withheld -> err_timeout exactly TIMEOUT cycles after WAIT entry; busy drops next cycle; HI/LO unchanged.
- MTHI 0x1234 then reset asserted during a DIV in WAIT -> hi=lo=0, busy=0; subsequent core_done ignored.

Source files
------------

// File: rtl/hilo_unit_if.sv
// Request, core-handshake and HI/LO result signals of the hilo_unit.
// The slave modport is the unit itself; the master modport is its surroundings.
interface hilo_unit_if;
  logic        op_start;
  logic [2:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        core_start;
  logic        core_is_div;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_done;
  logic [31:0] core_res_hi;
  logic [31:0] core_res_lo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;
  logic        err_timeout;

  modport master (
    output op_start, op_code, rs_val, rt_val, core_done, core_res_hi, core_res_lo,
    input  core_start, core_is_div, core_a, core_b, hi, lo, busy, done, div0, err_timeout
  );

  modport slave (
    input  op_start, op_code, rs_val, rt_val, core_done, core_res_hi, core_res_lo,
    output core_start, core_is_div, core_a, core_b, hi, lo, busy, done, div0, err_timeout
  );
endinterface

// File: rtl/hilo_unit.sv
// Mult/div sequencer: feeds operand magnitudes to the iterative core, waits for it,
// applies sign fixup and owns the architectural HI/LO registers.
module hilo_unit #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 7
) (
  input logic        clk,
  input logic        reset,
  hilo_unit_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned DLEN = 2 * XLEN;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FIXUP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   core_a_q, core_a_d, core_b_q, core_b_d;
  logic              core_is_div_q, core_is_div_d;
  logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic              core_start_q, core_start_d;
  logic              done_q, done_d;
  logic              div0_q, div0_d;
  logic              err_timeout_q, err_timeout_d;
  logic              busy_q, busy_d;

  // Operand decode and magnitudes for the incoming request
  logic              op_signed, op_is_div, rs_neg, rt_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  assign op_signed = ~bus.op_code[0];
  assign op_is_div = bus.op_code[1];
  assign rs_neg    = op_signed & bus.rs_val[XLEN-1];
  assign rt_neg    = op_signed & bus.rt_val[XLEN-1];
  assign mag_a     = rs_neg ? (~bus.rs_val + XLEN'(1)) : bus.rs_val;
  assign mag_b     = rt_neg ? (~bus.rt_val + XLEN'(1)) : bus.rt_val;

  // Sign-corrected results from the latched unsigned core output
  logic [DLEN-1:0]   prod, prod_neg;
  logic [XLEN-1:0]   quot_neg, rem_neg;
  assign prod     = {res_hi_q, res_lo_q};
  assign prod_neg = ~prod + DLEN'(1);
  assign quot_neg = ~res_lo_q + XLEN'(1);
  assign rem_neg  = ~res_hi_q + XLEN'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    core_a_d      = core_a_q;
    core_b_d      = core_b_q;
    core_is_div_d = core_is_div_q;
    neg_res_d     = neg_res_q;
    neg_rem_d     = neg_rem_q;
    res_hi_d      = res_hi_q;
    res_lo_d      = res_lo_q;
    core_start_d  = 1'b0;
    done_d        = 1'b0;
    div0_d        = 1'b0;
    err_timeout_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.op_start) begin
          unique case (bus.op_code)
            OP_MTHI: hi_d = bus.rs_val;
            OP_MTLO: lo_d = bus.rs_val;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              if (op_is_div && (bus.rt_val == '0)) begin
                div0_d = 1'b1;
              end else begin
                core_a_d      = mag_a;
                core_b_d      = mag_b;
                core_is_div_d = op_is_div;
                neg_res_d     = rs_neg ^ rt_neg;
                neg_rem_d     = rs_neg;
                core_start_d  = 1'b1;
                state_d       = S_LAUNCH;
              end
            end
            default: ;
          endcase
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A completion on the final counted cycle still wins over the abort
        if (bus.core_done) begin
          res_hi_d = bus.core_res_hi;
          res_lo_d = bus.core_res_lo;
          state_d  = S_FIXUP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_FIXUP: begin
        if (core_is_div_q) begin
          lo_d = neg_res_q ? quot_neg : res_lo_q;
          hi_d = neg_rem_q ? rem_neg  : res_hi_q;
        end else begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : prod;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      core_a_q      <= '0;
      core_b_q      <= '0;
      core_is_div_q <= 1'b0;
      neg_res_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      res_hi_q      <= '0;
      res_lo_q      <= '0;
      core_start_q  <= 1'b0;
      done_q        <= 1'b0;
      div0_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      core_a_q      <= core_a_d;
      core_b_q      <= core_b_d;
      core_is_div_q <= core_is_div_d;
      neg_res_q     <= neg_res_d;
      neg_rem_q     <= neg_rem_d;
      res_hi_q      <= res_hi_d;
      res_lo_q      <= res_lo_d;
      core_start_q  <= core_start_d;
      done_q        <= done_d;
      div0_q        <= div0_d;
      err_timeout_q <= err_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.core_start  = core_start_q;
  assign bus.core_is_div = core_is_div_q;
  assign bus.core_a      = core_a_q;
  assign bus.core_b      = core_b_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div0        = div0_q;
  assign bus.err_timeout = err_timeout_q;
endmodule
